// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-FF input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to receive 8E1 frames and flag parity mismatches.
module uart_rx #(
    parameter int clk_freq = 12000000,
    parameter int baud     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int DIV  = clk_freq / baud;
    localparam int HALF = DIV >> 1;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] LIM_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] LIM_FULL = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
`ifdef UART_RX_PARITY_EN
        , PAR = 3'd5
`endif
    } state_t;

    state_t          state, nxt;
    logic            sync1, rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            tick, pe_now;
    logic            set_v, set_fe, set_pe;

`ifdef UART_RX_PARITY_EN
    logic            par_bit;
    assign pe_now = par_bit != (^shift);
`else
    assign pe_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    // Sampling only happens in timed states; IDLE and BRK keep the counter at 0.
    assign tick = (state != IDLE) && (state != BRK) &&
                  (cnt == ((state == START) ? LIM_HALF : LIM_FULL));

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt    = state;
        set_v  = 1'b0;
        set_fe = 1'b0;
        set_pe = 1'b0;
        case (state)
            IDLE:  if (!rx_s) nxt = START;
            START: if (tick) nxt = rx_s ? IDLE : DATA;
            DATA: begin
                if (tick && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    nxt = PAR;
`else
                    nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PAR:   if (tick) nxt = STOP;
`endif
            STOP: begin
                if (tick) begin
                    // A low stop bit wins over any parity verdict.
                    if (!rx_s) begin
                        set_fe = 1'b1;
                        nxt    = BRK;
                    end else if (pe_now) begin
                        set_pe = 1'b1;
                        nxt    = IDLE;
                    end else begin
                        set_v  = 1'b1;
                        nxt    = IDLE;
                    end
                end
            end
            BRK:   if (rx_s) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'h00;
            data       <= 8'h00;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            if (tick || nxt != state || state == IDLE || state == BRK) cnt <= '0;
            else                                                      cnt <= cnt + 1'b1;
            if (state == START) bit_idx <= 3'd0;
            if (state == DATA && tick) begin
                shift   <= {rx_s, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (state == PAR && tick) par_bit <= rx_s;
`endif
            if (set_v) data <= shift;
            valid      <= set_v;
            frame_err  <= set_fe;
            parity_err <= set_pe;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean byte, false start, framing error,
// back-to-back frames, mid-frame reset, and (with UART_RX_PARITY_EN) parity.
module tb_uart_rx;
    localparam int DIV = 104;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, busy;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int fall = 0;
    int multi = 0;
    int v_cyc[$];
    int fe_cyc[$];
    int pe_cyc[$];
    logic [7:0] v_dat[$];

    uart_rx dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
        .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(data);
        end
        if (frame_err)  fe_cyc.push_back(cyc);
        if (parity_err) pe_cyc.push_back(cyc);
        if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) multi = multi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_log();
        v_cyc.delete(); v_dat.delete(); fe_cyc.delete(); pe_cyc.delete();
    endtask

    task automatic hold(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    // Drives start + 8 data bits LSB first; caller drives parity/stop afterwards.
    task automatic send_head(input logic [7:0] b);
        @(negedge clk);
        rx   = 1'b0;
        fall = cyc;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) hold(b[i], DIV);
    endtask

    int t0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", data, 8'h00);
        chk("rst_strobes", {valid, frame_err, parity_err, busy}, 4'b0000);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Clean byte
        clear_log();
        send_head(8'hA5);
        t0 = fall + 2;
        hold(1'b1, DIV + 20);
        chk("a5_nvalid", v_cyc.size(), 1);
        if (v_cyc.size() > 0) begin
            chk("a5_cycle", v_cyc[0], t0 + 989);
            chk("a5_data", v_dat[0], 8'hA5);
        end
        chk("a5_noerr", fe_cyc.size() + pe_cyc.size(), 0);
        chk("a5_busy_low", busy, 1'b0);

        // False start: 20-cycle glitch
        clear_log();
        @(negedge clk);
        rx = 1'b0; fall = cyc; t0 = fall + 2;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        while (cyc < t0 + 30) @(negedge clk);
        chk("glitch_busy_mid", busy, 1'b1);
        while (cyc < t0 + 60) @(negedge clk);
        chk("glitch_idle", busy, 1'b0);
        repeat (200) @(negedge clk);
        chk("glitch_nostrobe", v_cyc.size() + fe_cyc.size() + pe_cyc.size(), 0);
        chk("glitch_data", data, 8'hA5);

        // Framing error, line held low 3 bit-times
        clear_log();
        send_head(8'h3C);
        t0 = fall + 2;
        hold(1'b0, 3 * DIV - 10);
        chk("fe_busy_held", busy, 1'b1);
        hold(1'b0, 10);
        hold(1'b1, 6);
        chk("fe_busy_released", busy, 1'b0);
        hold(1'b1, 200);
        chk("fe_count", fe_cyc.size(), 1);
        if (fe_cyc.size() > 0) chk("fe_cycle", fe_cyc[0], t0 + 989);
        chk("fe_novalid", v_cyc.size(), 0);
        chk("fe_data_kept", data, 8'hA5);

        // Back-to-back 0x00 then 0xFF
        clear_log();
        send_head(8'h00);
        rx = 1'b1;
        repeat (DIV - 1) @(negedge clk);
        send_head(8'hFF);
        hold(1'b1, DIV + 20);
        chk("b2b_count", v_cyc.size(), 2);
        if (v_cyc.size() == 2) begin
            chk("b2b_spacing", v_cyc[1] - v_cyc[0], 10 * DIV);
            chk("b2b_first", v_dat[0], 8'h00);
            chk("b2b_second", v_dat[1], 8'hFF);
        end
        chk("b2b_noerr", fe_cyc.size() + pe_cyc.size(), 0);

        // Reset during data bit 4 of 0x55
        clear_log();
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) hold(i[0] ? 1'b0 : 1'b1, DIV);
        hold(1'b1, 50);
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        chk("mid_rst_outs", {data, valid, frame_err, parity_err, busy}, 12'h000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (DIV * 8) @(negedge clk);
        chk("mid_rst_nostrobe", v_cyc.size() + fe_cyc.size() + pe_cyc.size(), 0);
        send_head(8'h81);
        t0 = fall + 2;
        hold(1'b1, DIV + 20);
        chk("post_rst_count", v_cyc.size(), 1);
        if (v_cyc.size() > 0) begin
            chk("post_rst_cycle", v_cyc[0], t0 + 989);
            chk("post_rst_data", v_dat[0], 8'h81);
        end

`ifdef UART_RX_PARITY_EN
        clear_log();
        send_head(8'h01);
        t0 = fall + 2;
        hold(1'b1, DIV);
        hold(1'b1, DIV + 20);
        chk("par_ok_count", v_cyc.size(), 1);
        if (v_cyc.size() > 0) chk("par_ok_cycle", v_cyc[0], t0 + 1093);
        chk("par_ok_data", data, 8'h01);
        clear_log();
        send_head(8'h01);
        t0 = fall + 2;
        hold(1'b0, DIV);
        hold(1'b1, DIV + 20);
        chk("par_bad_count", pe_cyc.size(), 1);
        if (pe_cyc.size() > 0) chk("par_bad_cycle", pe_cyc[0], t0 + 1093);
        chk("par_bad_novalid", v_cyc.size(), 0);
        chk("par_bad_data", data, 8'h01);
`endif

        chk("strobes_exclusive", multi, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation bound expired");
        $fatal(1);
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-level UART receiver for the image-receive path: recovers 8N1 frames from the asynchronous `rx` pin with its own bit-timing counter. The counter uses the same `clk_freq`/`baud` arithmetic as the board's baud generator. Each received byte is presented on `data` with a one-cycle `valid` strobe to the downstream pixel/frame-buffer writer. Errored frames are flagged on separate strobes and never update `data`.

## Interface
- `clk_freq`, 12000000, system clock frequency in Hz.
- `baud`, 115200, line rate. Derived values:
  - DIV = clk_freq/baud (integer division), 104 at defaults.
  - HALF = DIV>>1, 52 at defaults.
  - Counter width = $clog2(DIV).
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `rx`  input  1  serial line, idle high, asynchronous to `clk`.
- `data`  output  8  last correctly received byte.
- `valid`  output  1  one-cycle pulse: `data` updated this cycle.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  output  1  one-cycle pulse: parity mismatch (tied 0 without the macro).
- `busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer. Both flops reset to 1. The FSM sees only the synchronized `rx_s`.
- Bit counter counts 0..N-1. A sample is taken in the cycle the counter equals N-1. The counter clears on every sample and on every state entry.
- States:
  - IDLE: counter held at 0. `rx_s`==0 -> START.
  - START: N=HALF. Sample `rx_s`==1 -> IDLE (false start, no strobe). Sample 0 -> DATA, bit index 0.
  - DATA: N=DIV. Shift the sample into shift register LSB first. After the 8th sample -> STOP, or -> PARITY when the macro is defined.
  - PARITY (macro only): N=DIV. Latch the sample, then -> STOP.
  - STOP: N=DIV.
    - Sample 1 with no parity error: `data`<=shift register, `valid` pulse next cycle, -> IDLE.
    - Sample 1 with parity error: `parity_err` pulse, `data` unchanged, -> IDLE.
    - Sample 0: `frame_err` pulse, `data` unchanged, -> BREAK. A frame error takes precedence over a parity error; only `frame_err` pulses.
  - BREAK: wait for `rx_s`==1, then -> IDLE. Prevents a held-low line from retriggering.
- Back-to-back frames: IDLE is entered on the cycle after the stop sample, so a start edge arriving half a bit later is caught.
- At most one of `valid`/`frame_err`/`parity_err` is high in any cycle.
- Reset values: `data`=0x00; `valid`, `frame_err`, `parity_err`, `busy` = 0; FSM in IDLE; counter and shift register 0; sync flops 1.
- Reset asserted mid-frame aborts immediately. No strobe is produced for the partial byte.

## Timing
- t0 = first cycle with `rx_s`==0. This is 2 clocks after `rx` falls, ±1 for metastability.
- Start-bit sample: t0+HALF.
- Data bit i (i=0..7) sampled at t0+HALF+(i+1)·DIV.
- Stop sample: t0+HALF+9·DIV. With the macro: t0+HALF+10·DIV.
- `valid`/`frame_err`/`parity_err` registered one cycle after the stop sample.
  - Defaults, no macro: t0+989.
- `busy` rises at t0+1. It falls in the same cycle as the strobe, or when BREAK exits.
- Tolerates ±2% baud mismatch with mid-bit sampling.

## Configuration
- `UART_RX_PARITY_EN`, defined:
  - Frame is 8E1.
  - PARITY state is compiled in.
  - Expected parity bit = XOR of the 8 data bits (even parity).
  - Mismatch produces a `parity_err` pulse and no `valid`.
- Undefined:
  - Frame is 8N1.
  - No PARITY state.
  - `parity_err` is constant 0.

## Test plan
- Clean byte: 0xA5, 8N1, exactly 104 clk/bit. Expect `data`=0xA5, a single `valid` at t0+989, no error strobes, `busy` low afterwards.
- False start: 20-cycle low glitch on `rx`. Expect FSM back to IDLE at t0+52, no strobes, `data` unchanged.
- Framing error: 0x3C with stop bit 0 and line held low 3 bit-times.
  - Expect one `frame_err` at t0+989 and `data` keeps its previous value.
  - Expect `busy` to stay high until `rx` returns high, with no retrigger.
- Back-to-back: 0x00 then 0xFF, with a 1-bit stop and no idle gap. Expect two `valid` pulses exactly 10·DIV apart, carrying 0x00 then 0xFF.
- Reset mid-frame: assert `rst` during data bit 4 of 0x55.
  - Expect all outputs 0 immediately and no `valid`.
  - Then a following 0x81 frame is received correctly.
- Parity, with `UART_RX_PARITY_EN`:
  - 0x01 with parity bit 1: `valid` at t0+1093.
  - 0x01 with parity bit 0: `parity_err` at t0+1093, no `valid`, `data` unchanged.
